// File: rtl/wb_sdrc_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing the sdrc_top slave port.
// Optional watchdog release: define WB_ARB_TIMEOUT_EN.
module wb_sdrc_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 26,
    parameter int DW          = 32,
    parameter int SW          = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*AW-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [DW-1:0]             m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [AW-1:0]             s_addr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [SW-1:0]             s_sel_o,
    output logic [2:0]                s_cti_o,
    input  logic                      s_ack_i,
    input  logic [DW-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      busy_o
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] pick;
    logic [PW-1:0]          owner_idx;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   timeout;

    // Rotating search for the first requester at or after the pointer.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && m_cyc_i[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Owner index and owner handshake bits decoded from the one-hot grant.
    always_comb begin
        owner_idx = '0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                owner_idx = PW'(k);
                owner_cyc = m_cyc_i[k];
                owner_stb = m_stb_i[k];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;

    // Watchdog counts unacknowledged strobe cycles of the current owner.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE || s_ack_i) wdog_d = '0;
        else if (owner_stb)             wdog_d = wdog_q + 16'd1;
    end

    // Watchdog register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wdog_q <= '0;
        else          wdog_q <= wdog_d;
    end

    assign timeout = (state_q == OWNED) && (wdog_q == 16'(TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    // State, grant and pointer registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: grant on any request, release when the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d = OWNED;
                    grant_d = pick;
                end
            end
            OWNED: begin
                if (!owner_cyc || timeout) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_idx == PW'(NUM_MASTERS - 1)) ?
                              '0 : owner_idx + PW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: route only the owner to the slave and back.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m_dat_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        if (state_q == OWNED) begin
            s_cyc_o = owner_cyc & ~timeout;
            s_stb_o = owner_stb & ~timeout;
            m_dat_o = s_dat_i;
            m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
            m_err_o = grant_q & {NUM_MASTERS{timeout}};
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (grant_q[k]) begin
                    s_we_o   = m_we_i[k];
                    s_addr_o = m_addr_i[k*AW +: AW];
                    s_dat_o  = m_dat_i[k*DW +: DW];
                    s_sel_o  = m_sel_i[k*SW +: SW];
                    s_cti_o  = m_cti_i[k*3 +: 3];
                end
            end
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == OWNED);

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Bench for wb_sdrc_arbiter: owner/pointer model plus directed scenarios.
// Built with WB_ARB_TIMEOUT_EN undefined.
module tb_wb_sdrc_arbiter;

    localparam int N  = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam logic [DW-1:0] SDAT_IDLE = 32'hA5A5_5A5A;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*SW-1:0] m_sel = '0;
    logic [N*3-1:0]  m_cti = '0;
    logic [N-1:0]    m_ack, m_err, grant;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc, s_stb, s_we, busy;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel;
    logic [2:0]      s_cti;
    logic            s_ack = 1'b0;
    logic [DW-1:0]   s_dat_i = SDAT_IDLE;

    int errors = 0;
    int checks = 0;

    wb_sdrc_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_cti_i(m_cti),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
        .s_cti_o(s_cti), .s_ack_i(s_ack), .s_dat_i(s_dat_i),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: owner (-1 = idle) and round-robin pointer as plain integers.
    int mo = -1;
    int mp = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mo = -1;
            mp = 0;
        end else if (mo < 0) begin
            for (int i = 0; i < N; i++)
                if (mo < 0 && m_cyc[(mp + i) % N]) mo = (mp + i) % N;
        end else if (!m_cyc[mo]) begin
            mp = (mo + 1) % N;
            mo = -1;
        end
    end

    logic [N-1:0]    e_grant, e_ack;
    logic [9:0]      e_ctl;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdat, e_rdat;

    // Every-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        e_grant = '0; e_ack = '0; e_ctl = '0;
        e_addr = '0; e_wdat = '0; e_rdat = '0;
        if (mo >= 0) begin
            e_grant[mo] = 1'b1;
            e_ack[mo]   = s_ack;
            e_ctl  = {m_cyc[mo], m_stb[mo], m_we[mo],
                      m_sel[mo*SW +: SW], m_cti[mo*3 +: 3]};
            e_addr = m_addr[mo*AW +: AW];
            e_wdat = m_dat[mo*DW +: DW];
            e_rdat = s_dat_i;
        end
        chk("cmp_grant", grant, e_grant);
        chk("cmp_busy", busy, mo >= 0);
        chk("cmp_ack", m_ack, e_ack);
        chk("cmp_err", m_err, '0);
        chk("cmp_ctl", {s_cyc, s_stb, s_we, s_sel, s_cti}, e_ctl);
        chk("cmp_addr", s_addr, e_addr);
        chk("cmp_wdat", s_dat_o, e_wdat);
        chk("cmp_rdat", m_dat_o, e_rdat);
    end

    logic [DW-1:0] mem [int];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int m);
        logic [N-1:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    task automatic wait_grant(input int m, output int n);
        n = 0;
        while (grant !== oh(m) && n < 40) begin
            step();
            n++;
        end
        chk("grant_wait", grant, oh(m));
    endtask

    task automatic rst_pulse();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic req(input int m, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [2:0] cti);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = we;
        m_addr[m*AW +: AW] = a;
        m_dat[m*DW +: DW]  = d;
        m_sel[m*SW +: SW]  = '1;
        m_cti[m*3 +: 3]    = cti;
    endtask

    task automatic xfer(input int m, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output int n);
        req(m, we, a, d, 3'b000);
        wait_grant(m, n);
        chk("xfer_addr", s_addr, a);
        s_ack = 1'b1;
        if (!we) s_dat_i = mem.exists(int'(a)) ? mem[int'(a)] : '0;
        #1;
        chk("xfer_ack", m_ack, oh(m));
        rd = m_dat_o;
        if (we) mem[int'(a)] = d;
        step();
        s_ack = 1'b0;
        s_dat_i = SDAT_IDLE;
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        step();
    endtask

    logic [DW-1:0] rd;
    int n;
    int owner;

    initial begin
        // Reset with every master requesting.
        rst = 1'b1;
        m_cyc = '1;
        s_ack = 1'b1;
        repeat (3) step();
        chk("rst_grant", grant, '0);
        chk("rst_scyc", s_cyc, 1'b0);
        chk("rst_ack", m_ack, '0);
        chk("rst_mdat", m_dat_o, '0);
        s_ack = 1'b0;
        rst = 1'b0;
        step();
        chk("rst_first_grant", grant, 4'b0001);
        m_cyc = '0;
        step();
        step();

        // Single write then readback through master 2.
        xfer(2, 1'b1, 26'h0000100, 32'hDEADBEEF, rd, n);
        chk("wr_latency", n, 1);
        xfer(2, 1'b0, 26'h0000100, 32'h0, rd, n);
        chk("rd_data", rd, 32'hDEADBEEF);

        // Round-robin fairness with all masters requesting.
        rst_pulse();
        for (int m = 0; m < N; m++) req(m, 1'b0, AW'(m * 16), '0, 3'b000);
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (grant == '0 && n < 40) begin
                step();
                n++;
            end
            chk("rr_gap", n, 1);
            chk("rr_order", grant, oh(g % N));
            owner = g % N;
            s_ack = 1'b1;
            step();
            s_ack = 1'b0;
            m_cyc[owner] = 1'b0;
            step();
            chk("rr_idle", busy, 1'b0);
            m_cyc[owner] = 1'b1;
        end
        m_cyc = '0;
        m_stb = '0;
        step();
        step();

        // Pointer at 2 with requests 1011: master 3 wins.
        rst_pulse();
        xfer(1, 1'b1, 26'h0000040, 32'h1, rd, n);
        req(0, 1'b0, 26'h10, '0, 3'b000);
        req(1, 1'b0, 26'h20, '0, 3'b000);
        req(3, 1'b0, 26'h30, '0, 3'b000);
        step();
        chk("ptr2_winner", grant, 4'b1000);
        m_cyc = '0;
        m_stb = '0;
        step();
        step();

        // Burst lock: master 1 bursts eight beats while master 0 waits.
        req(1, 1'b0, 26'h0000200, '0, 3'b010);
        wait_grant(1, n);
        req(0, 1'b0, 26'h0000300, '0, 3'b000);
        for (int b = 0; b < 8; b++) begin
            m_cti[1*3 +: 3] = (b == 7) ? 3'b111 : 3'b010;
            m_addr[1*AW +: AW] = AW'(26'h200 + b * 4);
            if (b == 3) begin
                m_stb[1] = 1'b0;
                step();
                chk("burst_gap_hold", grant, 4'b0010);
                m_stb[1] = 1'b1;
            end
            s_ack = 1'b1;
            s_dat_i = 32'h0000_1000 + b;
            #1;
            chk("burst_ack", m_ack, 4'b0010);
            chk("burst_rdat", m_dat_o, 32'h0000_1000 + b);
            step();
            s_ack = 1'b0;
            s_dat_i = SDAT_IDLE;
        end
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        step();
        chk("burst_release", grant, '0);
        step();
        chk("burst_next", grant, 4'b0001);
        m_cyc = '0;
        m_stb = '0;
        step();
        step();

        // Asynchronous reset during master 3 beat 4.
        rst_pulse();
        req(3, 1'b0, 26'h0000400, '0, 3'b010);
        wait_grant(3, n);
        req(0, 1'b0, 26'h0000500, '0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1;
            step();
            s_ack = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_scyc", s_cyc, 1'b0);
        chk("arst_grant", grant, '0);
        step();
        rst = 1'b0;
        step();
        chk("arst_first", grant, 4'b0001);
        m_cyc = '0;
        m_stb = '0;
        step();
        step();

        // No watchdog in this build: an unacked owner keeps the grant.
        rst_pulse();
        req(1, 1'b1, 26'h0000600, 32'h55, 3'b000);
        wait_grant(1, n);
        req(2, 1'b0, 26'h0000700, '0, 3'b000);
        for (int c = 0; c < 40; c++) begin
            step();
            if (grant !== 4'b0010 || m_err !== '0) begin
                chk("hold_grant", grant, 4'b0010);
                chk("hold_err", m_err, '0);
            end
        end
        chk("hold_grant_end", grant, 4'b0010);
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        wait_grant(2, n);
        chk("hold_handover", n, 2);
        m_cyc = '0;
        m_stb = '0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_sdrc_arbiter.md
Name: wb_sdrc_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares the single Wishbone slave port of the SDRAM controller (sdrc_top) among NUM_MASTERS requesters.
- Sits between the masters (CPU, DMA, video, test drivers) and sdrc_top.
- Ownership is granted per Wishbone cycle (wb_cyc), so incremental bursts (wb_cti) pass through unbroken.
- Only the current owner is routed to the slave, and only the owner receives ack and read data.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- AW, 26, Wishbone address width.
- DW, 32, Wishbone data width.
- SW, 4, byte-select width (DW/8).
- TIMEOUT, 255, cycles without slave ack before a forced release (used only with the optional feature).

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*AW  packed addresses; master k occupies [k*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  packed write data.
- m_sel_i  in  NUM_MASTERS*SW  packed byte selects.
- m_cti_i  in  NUM_MASTERS*3  packed cycle-type identifiers.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master error (used only with the optional feature).
- m_dat_o  out  DW  read data, broadcast to all masters; valid only where m_ack_o is set.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to the sdrc_top slave port.
- s_addr_o  out  AW  to the sdrc_top slave port.
- s_dat_o  out  DW  to the sdrc_top slave port.
- s_sel_o  out  SW  to the sdrc_top slave port.
- s_cti_o  out  3  to the sdrc_top slave port.
- s_ack_i  in  1  from sdrc_top.
- s_dat_i  in  DW  from sdrc_top.
- grant_o  out  NUM_MASTERS  one-hot current owner (observability).
- busy_o  out  1  arbiter is in the OWNED state.

Behaviour:
- Reset (asynchronous, wb_rst_i=1), values hold while reset is asserted:
  - state=IDLE, grant_o=0, busy_o=0.
  - Round-robin pointer=0 (master 0 has highest priority first).
  - All s_* outputs=0; m_ack_o=0; m_err_o=0; m_dat_o=0.
- FSM, two states:
  - IDLE: if any m_cyc_i bit is set, select the first requesting master at or after the pointer, searching upward and wrapping modulo NUM_MASTERS. Register it into grant_o and go to OWNED.
  - OWNED: stay while the owner's m_cyc_i=1. When the owner's m_cyc_i=0 at a rising edge, go to IDLE, clear grant_o, and set pointer = owner+1 with wrap (NUM_MASTERS-1 wraps to 0).
- Grant latency:
  - A request arriving while IDLE is granted on the next edge, so s_cyc_o rises 1 cycle after m_cyc_i.
  - One dead IDLE cycle always separates two owners. No back-to-back handover.
- Muxing in OWNED is combinational from grant_o:
  - s_cyc_o = owner m_cyc_i; s_stb_o = owner m_stb_i.
  - Remaining s_* outputs are the owner's slices.
  - m_ack_o[owner] = s_ack_i; all other m_ack_o bits = 0.
  - m_dat_o = s_dat_i.
- In IDLE: s_cyc_o = s_stb_o = 0, and the other s_* outputs are driven 0.
- Lock: ownership holds across stb gaps while cyc stays high, and across full cti=3'b010 bursts ending in cti=3'b111.
- Non-owner requests are stalled, never acked, and never lost. They stay pending until granted.
- Owner drops cyc in the same cycle s_ack_i arrives: the ack is delivered, then release.
- Simultaneous requests: pointer order decides. Example with pointer=2 and requests 4'b1011: master 3 wins.
- Reset mid-burst: outputs are cleared immediately and asynchronously. Masters must restart their cycles.
- Protocol violations (owner drops cyc with stb high) are not checked; release happens as normal.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit watchdog counter clears on grant and on every s_ack_i.
  - It increments each OWNED cycle with s_stb_o=1 and s_ack_i=0.
  - When it reaches TIMEOUT: pulse m_err_o[owner] for 1 cycle, force s_cyc_o=s_stb_o=0 that cycle, go to IDLE, and advance the pointer.
  - The master must then drop cyc.
- When undefined:
  - No counter exists, m_err_o is tied to 0, and ownership lasts until the owner drops cyc.

Test Plan:
1. Reset: hold wb_rst_i=1 with all m_cyc_i=1 -> grant_o=0, s_cyc_o=0, all m_ack_o=0. Release reset -> grant_o=4'b0001 after one edge.
2. Single write: master 2 writes addr 26'h0000100, data 32'hDEADBEEF, sel 4'hF -> s_addr_o/s_dat_o match, m_ack_o=4'b0100 exactly on the s_ack_i cycle, readback via master 2 returns 32'hDEADBEEF.
3. Round-robin fairness: all four masters request continuously, each issuing single-beat cycles -> grant order 0,1,2,3,0, with exactly one IDLE cycle between grants.
4. Burst lock: master 1 runs an 8-beat cti=010 read burst while master 0 requests -> master 0 is not granted until master 1 drops cyc after cti=111. Master 0 receives 0 acks during the burst.
5. Async reset mid-burst: assert wb_rst_i between edges during master 3 beat 4 -> s_cyc_o=0 immediately. After release, pointer=0 and master 0 is granted first.
6. Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=16): slave model never acks master 1 -> m_err_o[1] pulses in cycle 16 after grant, then a pending master 2 is granted. With the macro off, the grant persists and m_err_o=0.
